uart_tx_arbiter: RTL

Round-robin arbiter that shares one `UART_Transmitter` between `NUM_REQ` byte producers. It sits between the producers and the transmitter, on the transmitter's clock domain. Each frame follows one sequence: capture one requester's byte, present it on `data`/`data_valid`, wait for `tx_busy` to rise, then wait for `tx_busy` to fall. It also guarantees `data_valid` is never high while the transmitter sits in its stop-bit state, so back-to-back frames from different requesters can never be merged.

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_tx_arbiter_if.sv | 37 +++
 rtl/uart_rr_picker.sv | 35 +++
 rtl/uart_tx_arbiter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// uart_pkg: shared state encodings and widths for the UART TX arbiter slice.
// Revision: 1.0
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int STATE_W = 2;
  localparam int BYTE_W  = 8;

  localparam logic [STATE_W-1:0] IDLE  = 2'b00;
  localparam logic [STATE_W-1:0] ISSUE = 2'b01;
  localparam logic [STATE_W-1:0] BUSY  = 2'b10;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = IDLE,
    ST_ISSUE = ISSUE,
    ST_BUSY  = BUSY
  } arb_state_e;

endpackage : uart_pkg

`default_nettype wire

// File: rtl/uart_tx_arbiter_if.sv
// ============================================================================
// uart_tx_arbiter_if: requester-side and transmitter-side signals of the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  localparam int GRANT_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic [BYTE_W-1:0]         tx_data;
  logic                      tx_data_valid;
  logic                      tx_busy;
  logic [GRANT_W-1:0]        grant_id;
  logic                      active;
  logic                      timeout_err;

  modport master (
    input  req_valid, req_data, tx_busy,
    output req_ready, tx_data, tx_data_valid, grant_id, active, timeout_err
  );

  modport slave (
    output req_valid, req_data, tx_busy,
    input  req_ready, tx_data, tx_data_valid, grant_id, active, timeout_err
  );

endinterface : uart_tx_arbiter_if

`default_nettype wire

// File: rtl/uart_rr_picker.sv
// ============================================================================
// uart_rr_picker: combinational find-first-set searching upward from rr_ptr, wrapping.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_rr_picker #(
  parameter int NUM_REQ = 4,
  localparam int GRANT_W = $clog2(NUM_REQ)
) (
  input  wire logic [NUM_REQ-1:0] req_valid,
  input  wire logic [GRANT_W-1:0] rr_ptr,
  output logic                    any_valid,
  output logic [GRANT_W-1:0]      winner
);

  int idx;

  // Scan offsets from farthest to nearest so the closest set bit is written last.
  always_comb begin
    winner = '0;
    idx    = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      idx = (int'(rr_ptr) + off) % NUM_REQ;
      if (req_valid[idx]) begin
        winner = GRANT_W'(idx);
      end
    end
  end

  assign any_valid = |req_valid;

endmodule : uart_rr_picker

`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// uart_tx_arbiter: round-robin sharing of one UART transmitter among NUM_REQ producers.
// Optional ISSUE watchdog enabled by macro UART_TX_ARB_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input wire logic          baud_clk,
  input wire logic          reset,
  uart_tx_arbiter_if.master bus
);

  localparam int GRANT_W = $clog2(NUM_REQ);

  arb_state_e         state_q, state_d;
  logic [BYTE_W-1:0]  hold_q, hold_d;
  logic [GRANT_W-1:0] grant_q, grant_d;
  logic [GRANT_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] ready_q, ready_d;
  logic               valid_q, valid_d;
  logic               any_valid;
  logic [GRANT_W-1:0] winner;

  uart_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req_valid (bus.req_valid),
    .rr_ptr    (rr_ptr_q),
    .any_valid (any_valid),
    .winner    (winner)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tout_q, tout_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_ff @(posedge baud_clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      ready_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  always_ff @(posedge baud_clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tout_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tout_q <= tout_d;
    end
  end
`endif

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    ready_d  = '0;
    valid_d  = valid_q;
`ifdef UART_TX_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    tout_d   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        // Granting waits for tx_busy low so a frame still in flight after reset finishes first.
        if (!bus.tx_busy && any_valid) begin
          hold_d          = bus.req_data[int'(winner)*BYTE_W +: BYTE_W];
          grant_d         = winner;
          ready_d[winner] = 1'b1;
          rr_ptr_d        = (winner == GRANT_W'(NUM_REQ - 1)) ? '0 : winner + GRANT_W'(1);
          valid_d         = 1'b1;
          state_d         = ST_ISSUE;
`ifdef UART_TX_ARB_TIMEOUT_EN
          cnt_d           = '0;
`endif
        end
      end
      ST_ISSUE: begin
        if (bus.tx_busy) begin
          valid_d = 1'b0;
          state_d = ST_BUSY;
        end
`ifdef UART_TX_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          valid_d = 1'b0;
          tout_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_BUSY: begin
        valid_d = 1'b0;
        if (!bus.tx_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.req_ready     = ready_q;
  assign bus.tx_data       = hold_q;
  assign bus.tx_data_valid = valid_q;
  assign bus.grant_id      = grant_q;
  assign bus.active        = (state_q != ST_IDLE);
`ifdef UART_TX_ARB_TIMEOUT_EN
  assign bus.timeout_err   = tout_q;
`else
  assign bus.timeout_err   = 1'b0;
`endif

endmodule : uart_tx_arbiter

`default_nettype wire
